// File: rtl/cnn_image_loader_pkg.sv
// Frame geometry and loader state encoding shared by generated_cnn and its image loader.
package cnn_image_loader_pkg;

  localparam int PIXEL_W    = 8;
  localparam int NUM_PIXELS = 784;
  localparam int IMG_W      = PIXEL_W * NUM_PIXELS;
  localparam int CNT_W      = $clog2(NUM_PIXELS + 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } load_state_e;

endpackage

// File: rtl/cnn_image_loader.sv
// Streams pixel bytes into the flat input_image vector of generated_cnn and holds the frame until acked.
// Optional s_last framing check and sticky frame_err are enabled by defining FRAME_CHECK_EN.
module cnn_image_loader
  import cnn_image_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [PIXEL_W-1:0] s_data,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               s_last,
  output logic [IMG_W-1:0]   input_image,
  output logic               image_valid,
  input  logic               image_ack,
  output logic [CNT_W-1:0]   pix_count,
  output logic               frame_err
);

  load_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_d;
  logic             xfer;
  logic             last_pix;
  logic             wr_en;
`ifdef FRAME_CHECK_EN
  logic             err_set;
  logic             err_q;
`endif

  assign s_ready     = (state_q == FILL) && !rst;
  assign xfer        = s_valid && s_ready;
  assign last_pix    = (pix_count == CNT_W'(NUM_PIXELS - 1));
  assign image_valid = (state_q == FULL);

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = pix_count;
    wr_en   = 1'b0;
`ifdef FRAME_CHECK_EN
    err_set = 1'b0;
`endif
    unique case (state_q)
      FILL: begin
        if (xfer) begin
          wr_en = 1'b1;
          if (last_pix) begin
            cnt_d   = '0;
            state_d = FULL;
`ifdef FRAME_CHECK_EN
            // Final pixel without s_last: drop the frame instead of presenting it.
            if (!s_last) begin
              state_d = FILL;
              err_set = 1'b1;
            end
`endif
          end else begin
            cnt_d = pix_count + 1'b1;
`ifdef FRAME_CHECK_EN
            if (s_last) begin
              cnt_d   = '0;
              err_set = 1'b1;
            end
`endif
          end
        end
      end
      FULL: begin
        if (image_ack) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // NOTE: the image buffer is reset on purpose: a reset must visibly zero input_image.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      pix_count   <= '0;
      input_image <= '0;
    end else begin
      state_q   <= state_d;
      pix_count <= cnt_d;
      if (wr_en) input_image[pix_count*PIXEL_W +: PIXEL_W] <= s_data;
    end
  end

`ifdef FRAME_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)          err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end
  assign frame_err = err_q;
`else
  logic unused_s_last;
  assign unused_s_last = s_last;
  assign frame_err     = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_image_loader.sv
// Directed bench for cnn_image_loader: stimulus queue feeds the stream, expected frames are scoreboarded.
`timescale 1ns/1ps
module tb_cnn_image_loader;
  import cnn_image_loader_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic [PIXEL_W-1:0] s_data;
  logic               s_valid;
  logic               s_ready;
  logic               s_last;
  logic [IMG_W-1:0]   input_image;
  logic               image_valid;
  logic               image_ack;
  logic [CNT_W-1:0]   pix_count;
  logic               frame_err;

  always #5 clk = ~clk;

  cnn_image_loader dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_last     (s_last),
    .input_image(input_image),
    .image_valid(image_valid),
    .image_ack  (image_ack),
    .pix_count  (pix_count),
    .frame_err  (frame_err)
  );

  typedef struct {
    logic [PIXEL_W-1:0] data;
    logic               last;
  } beat_t;

  beat_t            stim_q[$];
  logic [IMG_W-1:0] exp_q[$];
  logic [IMG_W-1:0] last_img;
  int               rise_cyc[$];
  int               total = 0;
  int               bad = 0;
  int               cyc = 0;
  int               valid_hi = 0;
  logic             prev_valid = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_img(input string tag, input logic [IMG_W-1:0] obs, input logic [IMG_W-1:0] exp);
    int first;
    first = 0;
    for (int i = NUM_PIXELS - 1; i >= 0; i--)
      if (obs[i*PIXEL_W +: PIXEL_W] !== exp[i*PIXEL_W +: PIXEL_W]) first = i;
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: pixel %0d observed %0h expected %0h", tag, first,
             obs[first*PIXEL_W +: PIXEL_W], exp[first*PIXEL_W +: PIXEL_W]);
    end
  endtask

  // Scoreboard: each rising image_valid must match the oldest expected frame.
  always @(negedge clk) begin
    logic v;
    v = (image_valid === 1'b1);
    if (v) valid_hi++;
    if (v && !prev_valid) begin
      rise_cyc.push_back(cyc);
      check("frame_expected", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check_img("frame_data", input_image, exp_q.pop_front());
    end
    prev_valid = v;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic add_frame(input int seed, input int n, input int last_at, input bit deliver);
    logic [IMG_W-1:0] img;
    img = '0;
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.data = PIXEL_W'((i + seed) % 256);
      b.last = (i == last_at);
      stim_q.push_back(b);
      img[i*PIXEL_W +: PIXEL_W] = b.data;
    end
    if (deliver) begin
      exp_q.push_back(img);
      last_img = img;
    end
  endtask

  // Drains stim_q; gap=1 toggles s_valid every other cycle. Returns cycles spent.
  task automatic send(input bit gap, input int budget, output int cycles);
    bit hs;
    cycles = 0;
    while (stim_q.size() > 0 && cycles < budget) begin
      s_valid = gap ? ((cycles % 2) == 0) : 1'b1;
      s_data  = stim_q[0].data;
      s_last  = stim_q[0].last;
      hs      = s_valid && s_ready;
      tick(1);
      cycles++;
      if (hs) void'(stim_q.pop_front());
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    check("send_drained", stim_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c, start, vh0, nrise;

    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; image_ack = 1'b0;
    last_img = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready_low", s_ready, 0);
    rst = 1'b0;
    #1;
    check("rst_pix_count", pix_count, 0);
    check("rst_image_valid", image_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_ready", s_ready, 1);
    check_img("rst_image", input_image, '0);

    // Back-to-back stream of i%256.
    add_frame(0, NUM_PIXELS, NUM_PIXELS - 1, 1'b1);
    start = cyc;
    send(1'b0, 4000, c);
    check("s1_cycles", c, NUM_PIXELS);
    check("s1_valid", image_valid, 1);
    check("s1_ready", s_ready, 0);
    check("s1_pix_count", pix_count, 0);
    check("s1_frame_err", frame_err, 0);
    tick(1);
    check("s1_latency", rise_cyc[rise_cyc.size()-1] - start, NUM_PIXELS);

    // FULL ignores s_valid; ack cycle accepts nothing.
    s_valid = 1'b1; s_data = 8'hAA;
    tick(10);
    check_img("hold_data", input_image, last_img);
    check("hold_valid", image_valid, 1);
    check("hold_pix_count", pix_count, 0);
    image_ack = 1'b1;
    tick(1);
    image_ack = 1'b0;
    s_valid = 1'b0;
    check("ack_valid", image_valid, 0);
    check("ack_ready", s_ready, 1);
    check("ack_pix_count", pix_count, 0);
    check_img("ack_no_write", input_image, last_img);

    // s_valid toggling every other cycle.
    add_frame(0, NUM_PIXELS, NUM_PIXELS - 1, 1'b1);
    send(1'b1, 4000, c);
    check("s3_cycles_to_valid", c + 1, 2 * NUM_PIXELS);
    check("s3_valid", image_valid, 1);
    tick(1);
    image_ack = 1'b1;
    tick(1);
    image_ack = 1'b0;

    // Reset mid-frame, then a clean frame, then reset while FULL.
    add_frame(7, 300, -1, 1'b0);
    send(1'b0, 4000, c);
    check("s4_partial_count", pix_count, 300);
    rst = 1'b1;
    tick(1);
    check("s4_rst_ready", s_ready, 0);
    rst = 1'b0;
    #1;
    check("s4_pix_count", pix_count, 0);
    check("s4_valid", image_valid, 0);
    check_img("s4_image_zero", input_image, '0);
    add_frame(5, NUM_PIXELS, NUM_PIXELS - 1, 1'b1);
    send(1'b0, 4000, c);
    check("s4_valid_after", image_valid, 1);
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    #1;
    check("full_rst_valid", image_valid, 0);
    check("full_rst_ready", s_ready, 1);

    // Two frames with ack held high: one-cycle valid each, 785-cycle period.
    image_ack = 1'b1;
    vh0 = valid_hi;
    nrise = rise_cyc.size();
    add_frame(11, NUM_PIXELS, NUM_PIXELS - 1, 1'b1);
    add_frame(99, NUM_PIXELS, NUM_PIXELS - 1, 1'b1);
    send(1'b0, 4000, c);
    check("s5_cycles", c, 2 * NUM_PIXELS + 1);
    tick(1);
    image_ack = 1'b0;
    check("s5_rises", rise_cyc.size() - nrise, 2);
    check("s5_period", rise_cyc[rise_cyc.size()-1] - rise_cyc[rise_cyc.size()-2], NUM_PIXELS + 1);
    check("s5_valid_cycles", valid_hi - vh0, 2);
    check("s5_valid_low", image_valid, 0);

`ifdef FRAME_CHECK_EN
    // Early s_last, then missing s_last, then a good frame.
    nrise = rise_cyc.size();
    add_frame(3, 501, 500, 1'b0);
    send(1'b0, 4000, c);
    tick(1);
    check("early_err", frame_err, 1);
    check("early_pix_count", pix_count, 0);
    check("early_valid", image_valid, 0);
    add_frame(1, NUM_PIXELS, -1, 1'b0);
    send(1'b0, 4000, c);
    tick(1);
    check("missing_valid", image_valid, 0);
    check("missing_pix_count", pix_count, 0);
    check("no_bad_rise", rise_cyc.size() - nrise, 0);
    add_frame(9, NUM_PIXELS, NUM_PIXELS - 1, 1'b1);
    send(1'b0, 4000, c);
    check("fc_valid", image_valid, 1);
    tick(1);
    check("fc_err_sticky", frame_err, 1);
    image_ack = 1'b1;
    tick(1);
    image_ack = 1'b0;
`else
    check("err_tied_low", frame_err, 0);
`endif

    tick(2);
    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
